m_dram_port: RTL and testbench

- Sits directly downstream of the MMU. It consumes the MMU's DRAM request signals: address, write data, write strobe, load strobe and funct3 control.
- It converts each request into one or two word-wide req/ack transactions on the external memory port.
- Byte/halfword loads get byte-lane extraction and sign/zero extension; stores get byte enables. Accesses that cross a word boundary are split into two beats.
- It drives the busy and read-data signals back to the MMU.

---
 rtl/m_dram_port_if.sv | 15 +
 rtl/m_dram_port.sv | 183 ++++++++++++++++++
 tb/tb_m_dram_port.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_dram_port_if.sv
// Word-wide req/ack memory port between m_dram_port (master) and the DRAM side (slave).
interface m_dram_port_if #(
    parameter int unsigned ADDR_W = 25
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/m_dram_port.sv
// MMU-to-DRAM adapter: turns one MMU load/store into one or two word beats on the
// req/ack port, with lane alignment, byte enables and load extension.
// Optional feature macro: DRAM_PORT_SPLIT_EN (split word-crossing accesses into two beats).
// Without it, H/W offsets are dropped and any H/W access with a non-zero offset raises err.
module m_dram_port #(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic [31:0]   w_dram_addr,
    input  logic [31:0]   w_dram_wdata,
    input  logic          w_dram_we_t,
    input  logic          w_dram_le,
    input  logic [2:0]    w_dram_ctrl,
    output logic [31:0]   w_dram_odata,
    output logic          w_dram_busy,
    output logic          w_dram_err,
    m_dram_port_if.master dmem
);
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {StIdle, StBeat0, StGap, StBeat1, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              store_q, store_d;
    logic [31:0]       buf_lo_q, buf_lo_d, buf_hi_q, buf_hi_d;
    logic [31:0]       odata_q, odata_d;
    logic              busy_q, busy_d, err_q, err_d;

    logic [1:0]        off;
    logic [3:0]        size_mask;
    logic [7:0]        mask8;
    logic [63:0]       data64, rd64;
    logic [31:0]       sh, ld_val;
    logic              split, misaligned;
    logic [ADDR_W-1:0] wa;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^w_dram_addr[31:ADDR_W+2];

    // Beat shaping from the latched request
    always_comb begin
        case (ctrl_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
`ifdef DRAM_PORT_SPLIT_EN
        off   = addr_q[1:0];
        mask8 = {4'b0000, size_mask} << off;
        split = (mask8[7:4] != 4'b0000);
`else
        off   = (ctrl_q[1:0] == 2'b00) ? addr_q[1:0] : 2'b00;
        mask8 = {4'b0000, size_mask} << off;
        split = 1'b0;
`endif
        data64 = {32'h0, wdata_q} << {off, 3'b000};
        wa     = addr_q[ADDR_W+1:2];
    end

    // Misaligned H/W flag on the incoming request (only meaningful without splitting)
    always_comb begin
`ifdef DRAM_PORT_SPLIT_EN
        misaligned = 1'b0;
`else
        misaligned = (w_dram_ctrl[1:0] != 2'b00) && (w_dram_addr[1:0] != 2'b00);
`endif
    end

    // Load extraction; the beat being acked supplies its half of the buffer directly
    always_comb begin
        rd64 = (state_q == StBeat1) ? {dmem.rdata, buf_lo_q} : {buf_hi_q, dmem.rdata};
        sh   = 32'(rd64 >> {off, 3'b000});
        case (ctrl_q)
            3'b000:  ld_val = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ld_val = {24'h0, sh[7:0]};
            3'b001:  ld_val = {{16{sh[15]}}, sh[15:0]};
            3'b101:  ld_val = {16'h0, sh[15:0]};
            default: ld_val = sh;
        endcase
    end

    // Next-state, datapath updates and memory-port drive
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ctrl_d     = ctrl_q;
        store_d    = store_q;
        buf_lo_d   = buf_lo_q;
        buf_hi_d   = buf_hi_q;
        odata_d    = odata_q;
        err_d      = 1'b0;
        dmem.req   = 1'b0;
        dmem.we    = 1'b0;
        dmem.addr  = '0;
        dmem.wdata = 32'h0;
        dmem.be    = 4'h0;
        unique case (state_q)
            StIdle: begin
                if (w_dram_we_t || w_dram_le) begin
                    addr_d  = w_dram_addr[ADDR_W+1:0];
                    wdata_d = w_dram_wdata;
                    ctrl_d  = w_dram_ctrl;
                    store_d = w_dram_we_t;
                    err_d   = misaligned;
                    cnt_d   = '0;
                    state_d = StBeat0;
                end
            end
            StBeat0, StBeat1: begin
                dmem.req   = 1'b1;
                dmem.we    = store_q;
                dmem.addr  = (state_q == StBeat1) ? wa + ADDR_W'(1) : wa;
                dmem.wdata = (state_q == StBeat1) ? data64[63:32] : data64[31:0];
                dmem.be    = !store_q ? 4'hF : (state_q == StBeat1) ? mask8[7:4] : mask8[3:0];
                if (dmem.ack) begin
                    if (state_q == StBeat0) buf_lo_d = dmem.rdata;
                    else                    buf_hi_d = dmem.rdata;
                    if (state_q == StBeat0 && split) begin
                        state_d = StGap;
                    end else begin
                        state_d = StDone;
                        if (!store_q) odata_d = ld_val;
                    end
                end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    // Abort: ack never arrived within the beat budget
                    state_d = StIdle;
                    err_d   = 1'b1;
                    odata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StGap: begin
                cnt_d   = '0;
                state_d = StBeat1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StBeat0) || (state_d == StGap) || (state_d == StBeat1);
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            ctrl_q   <= 3'b000;
            store_q  <= 1'b0;
            buf_lo_q <= 32'h0;
            buf_hi_q <= 32'h0;
            odata_q  <= 32'h0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ctrl_q   <= ctrl_d;
            store_q  <= store_d;
            buf_lo_q <= buf_lo_d;
            buf_hi_q <= buf_hi_d;
            odata_q  <= odata_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign w_dram_odata = odata_q;
    assign w_dram_busy  = busy_q;
    assign w_dram_err   = err_q;
endmodule

// File: tb/tb_m_dram_port.sv
// Directed table-driven bench for m_dram_port, plus hand-written multi-cycle sequences.
module tb_m_dram_port;
    localparam int unsigned AW = 25;

    logic        clk = 1'b0;
    logic        rst_x;
    logic [31:0] addr, wdata, odata;
    logic        we_t, le, busy, err;
    logic [2:0]  ctrl;

    always #5 clk = ~clk;

    m_dram_port_if #(.ADDR_W(AW)) dmem_if ();

    m_dram_port #(.ADDR_W(AW), .TIMEOUT_CYC(1024)) dut (
        .CLK         (clk),
        .RST_X       (rst_x),
        .w_dram_addr (addr),
        .w_dram_wdata(wdata),
        .w_dram_we_t (we_t),
        .w_dram_le   (le),
        .w_dram_ctrl (ctrl),
        .w_dram_odata(odata),
        .w_dram_busy (busy),
        .w_dram_err  (err),
        .dmem        (dmem_if)
    );

    typedef struct {
        logic        we_t;
        logic        le;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] m0;
        logic [31:0] m1;
        int          delay;
        int          beats;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic        wr;
        logic [31:0] odata;
        int          busy;
        int          gap;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void add_ld(logic [2:0] c, logic [31:0] a, logic [31:0] m0,
                                   logic [31:0] m1, int d, int nb, logic [31:0] a0,
                                   logic [31:0] a1, logic [31:0] od, int bz, logic e);
        vec_t v;
        v.we_t = 1'b0; v.le = 1'b1; v.ctrl = c; v.addr = a; v.wdata = 32'h0;
        v.m0 = m0; v.m1 = m1; v.delay = d; v.beats = nb; v.a0 = a0; v.a1 = a1;
        v.be0 = 4'hF; v.be1 = 4'hF; v.wd0 = 32'h0; v.wd1 = 32'h0; v.wr = 1'b0;
        v.odata = od; v.busy = bz; v.gap = (nb == 2) ? 1 : 0; v.err = e;
        vecs.push_back(v);
    endfunction

    // Stores use a one-cycle ack delay; od is the unchanged previous load result
    function automatic void add_st(logic both, logic [2:0] c, logic [31:0] a, logic [31:0] wd,
                                   int nb, logic [31:0] a0, logic [31:0] a1, logic [3:0] be0,
                                   logic [3:0] be1, logic [31:0] wd0, logic [31:0] wd1,
                                   logic [31:0] od, int bz, logic e);
        vec_t v;
        v.we_t = 1'b1; v.le = both; v.ctrl = c; v.addr = a; v.wdata = wd;
        v.m0 = 32'hDEADBEEF; v.m1 = 32'hDEADBEEF; v.delay = 1; v.beats = nb; v.a0 = a0;
        v.a1 = a1; v.be0 = be0; v.be1 = be1; v.wd0 = wd0; v.wd1 = wd1; v.wr = 1'b1;
        v.odata = od; v.busy = bz; v.gap = (nb == 2) ? 1 : 0; v.err = e;
        vecs.push_back(v);
    endfunction

    task automatic run(input vec_t v, input int idx);
        int          bcyc, nb, gaps, busyc;
        logic        errs, done;
        logic [31:0] ga[2], gwd[2];
        logic [3:0]  gbe[2];
        logic        gwe[2];
        bcyc = 0; nb = 0; gaps = 0; busyc = 0; errs = 1'b0; done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ga[i] = 32'h0; gwd[i] = 32'h0; gbe[i] = 4'h0; gwe[i] = 1'b0;
        end
        @(negedge clk);
        addr = v.addr; wdata = v.wdata; ctrl = v.ctrl; we_t = v.we_t; le = v.le;
        @(posedge clk);
        @(negedge clk);
        we_t = 1'b0; le = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (c > 0) @(negedge clk);
            dmem_if.ack = 1'b0;
            errs = errs | err;
            if (!busy) begin
                done = 1'b1;
            end else begin
                busyc++;
                if (dmem_if.req) begin
                    if (bcyc == v.delay) begin
                        if (nb < 2) begin
                            ga[nb]  = 32'(dmem_if.addr);
                            gbe[nb] = dmem_if.be;
                            gwd[nb] = dmem_if.wdata;
                            gwe[nb] = dmem_if.we;
                            dmem_if.rdata = (nb == 0) ? v.m0 : v.m1;
                        end
                        dmem_if.ack = 1'b1;
                        nb++;
                        bcyc = 0;
                    end else begin
                        bcyc++;
                    end
                end else begin
                    gaps++;
                end
            end
        end
        chk($sformatf("v%0d completes", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d beats", idx), nb, v.beats);
        chk($sformatf("v%0d addr0", idx), ga[0], v.a0);
        chk($sformatf("v%0d be0", idx), 32'(gbe[0]), 32'(v.be0));
        chk($sformatf("v%0d we0", idx), 32'(gwe[0]), 32'(v.wr));
        if (v.wr) chk($sformatf("v%0d wdata0", idx), gwd[0], v.wd0);
        if (v.beats == 2) begin
            chk($sformatf("v%0d addr1", idx), ga[1], v.a1);
            chk($sformatf("v%0d be1", idx), 32'(gbe[1]), 32'(v.be1));
            if (v.wr) chk($sformatf("v%0d wdata1", idx), gwd[1], v.wd1);
        end
        chk($sformatf("v%0d gap", idx), gaps, v.gap);
        chk($sformatf("v%0d odata", idx), odata, v.odata);
        chk($sformatf("v%0d busy cycles", idx), busyc, v.busy);
        chk($sformatf("v%0d err", idx), 32'(errs), 32'(v.err));
    endtask

    initial begin
        int   rise[2];
        int   nr, rc;
        logic prev;

        rst_x = 1'b0; we_t = 1'b0; le = 1'b0; addr = 32'h0; wdata = 32'h0; ctrl = 3'b000;
        dmem_if.ack = 1'b0; dmem_if.rdata = 32'h0;

        //      ctrl    addr          m0            m1            d  nb a0     a1     odata      busy err
        add_ld(3'b010, 32'h80000100, 32'h11223344, 32'h0,        3, 1, 32'h40, 32'h0, 32'h11223344, 4, 0);
        add_ld(3'b000, 32'h80000103, 32'h80FF0000, 32'h0,        1, 1, 32'h40, 32'h0, 32'hFFFFFF80, 2, 0);
        add_ld(3'b100, 32'h80000103, 32'h80FF0000, 32'h0,        0, 1, 32'h40, 32'h0, 32'h00000080, 1, 0);
        add_ld(3'b101, 32'h80000100, 32'h1234F00D, 32'h0,        0, 1, 32'h40, 32'h0, 32'h0000F00D, 1, 0);
        add_ld(3'b001, 32'h80000100, 32'h1234F00D, 32'h0,        0, 1, 32'h40, 32'h0, 32'hFFFFF00D, 1, 0);
        //     both ctrl    addr          wdata         nb a0     a1    be0    be1    wd0           wd1    odata         busy err
        add_st(0, 3'b000, 32'h80000202, 32'h000000A5, 1, 32'h80, 32'h0, 4'h4, 4'h0, 32'h00A50000, 32'h0, 32'hFFFFF00D, 2, 0);
        add_st(0, 3'b010, 32'h80000204, 32'hCAFEF00D, 1, 32'h81, 32'h0, 4'hF, 4'h0, 32'hCAFEF00D, 32'h0, 32'hFFFFF00D, 2, 0);
        add_st(1, 3'b010, 32'h80000300, 32'h01020304, 1, 32'hC0, 32'h0, 4'hF, 4'h0, 32'h01020304, 32'h0, 32'hFFFFF00D, 2, 0);
        add_ld(3'b111, 32'h80000100, 32'h89ABCDEF, 32'h0,        2, 1, 32'h40, 32'h0, 32'h89ABCDEF, 3, 0);
        add_ld(3'b000, 32'h80000101, 32'h0000C300, 32'h0,        0, 1, 32'h40, 32'h0, 32'hFFFFFFC3, 1, 0);
`ifdef DRAM_PORT_SPLIT_EN
        add_st(0, 3'b001, 32'h80000001, 32'h0000ABCD, 1, 32'h0, 32'h0, 4'h6, 4'h0, 32'h00ABCD00, 32'h0, 32'hFFFFFFC3, 2, 0);
        add_ld(3'b101, 32'h80000102, 32'h80FF0000, 32'h0,        0, 1, 32'h40, 32'h0, 32'h000080FF, 1, 0);
        add_ld(3'b010, 32'h80000006, 32'hDDCCBBAA, 32'h44332211, 0, 2, 32'h1, 32'h2, 32'h2211DDCC, 3, 0);
        add_st(0, 3'b010, 32'h80000003, 32'hA1B2C3D4, 2, 32'h0, 32'h1, 4'h8, 4'h7, 32'hD4000000, 32'h00A1B2C3, 32'h2211DDCC, 5, 0);
        add_ld(3'b010, 32'h07FFFFFE, 32'hBEEF0000, 32'h0000CAFE, 0, 2, 32'h1FFFFFF, 32'h0, 32'hCAFEBEEF, 3, 0);
        add_ld(3'b001, 32'h80000103, 32'hAB000000, 32'h000000F1, 1, 2, 32'h40, 32'h41, 32'hFFFFF1AB, 5, 0);
`else
        add_st(0, 3'b001, 32'h80000001, 32'h0000ABCD, 1, 32'h0, 32'h0, 4'h3, 4'h0, 32'h0000ABCD, 32'h0, 32'hFFFFFFC3, 2, 1);
        add_ld(3'b101, 32'h80000102, 32'h80FF0000, 32'h0,        0, 1, 32'h40, 32'h0, 32'h00000000, 1, 1);
        add_ld(3'b001, 32'h80000103, 32'h00C3F1AB, 32'h0,        0, 1, 32'h40, 32'h0, 32'hFFFFF1AB, 1, 1);
`endif

        repeat (3) @(negedge clk);
        chk("reset req", 32'(dmem_if.req), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset odata", odata, 32'h0);
        rst_x = 1'b1;

        foreach (vecs[i]) run(vecs[i], i);

        // Back-to-back: load strobe held across completion starts a second request
        @(negedge clk);
        addr = 32'h80000100; ctrl = 3'b010; we_t = 1'b0; le = 1'b1;
        nr = 0; prev = 1'b0; rise[0] = 0; rise[1] = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            dmem_if.ack = 1'b0;
            if (dmem_if.req) begin
                dmem_if.ack = 1'b1;
                dmem_if.rdata = 32'h5555AAAA;
                if (!prev) begin
                    if (nr < 2) rise[nr] = c;
                    nr++;
                    if (nr >= 2) le = 1'b0;
                end
            end
            prev = dmem_if.req;
        end
        le = 1'b0;
        chk("b2b requests", nr, 2);
        chk("b2b spacing", rise[1] - rise[0], 3);
        chk("b2b odata", odata, 32'h5555AAAA);
        chk("b2b busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a beat (second beat when splitting)
        @(negedge clk);
        ctrl = 3'b010; le = 1'b1;
`ifdef DRAM_PORT_SPLIT_EN
        addr = 32'h80000006;
`else
        addr = 32'h80000100;
`endif
        @(posedge clk);
        @(negedge clk);
        le = 1'b0;
`ifdef DRAM_PORT_SPLIT_EN
        dmem_if.rdata = 32'h12345678; dmem_if.ack = 1'b1;
        @(negedge clk);
        dmem_if.ack = 1'b0;
        @(negedge clk);
`endif
        chk("rst pre req", 32'(dmem_if.req), 32'd1);
        chk("rst pre busy", 32'(busy), 32'd1);
        #2 rst_x = 1'b0;
        #1;
        chk("rst async req", 32'(dmem_if.req), 32'd0);
        chk("rst async busy", 32'(busy), 32'd0);
        chk("rst async odata", odata, 32'h0);
        @(negedge clk);
        rst_x = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst idle req", 32'(dmem_if.req), 32'd0);
        chk("rst idle busy", 32'(busy), 32'd0);

        run(vecs[0], 100);

        // Timeout: no ack ever
        @(negedge clk);
        addr = 32'h80000100; ctrl = 3'b010; le = 1'b1;
        @(posedge clk);
        @(negedge clk);
        le = 1'b0;
        rc = 0;
        for (int c = 0; c < 1100; c++) begin
            if (!dmem_if.req) break;
            rc++;
            @(negedge clk);
        end
        chk("tmo req cycles", rc, 1024);
        chk("tmo req low", 32'(dmem_if.req), 32'd0);
        chk("tmo err pulse", 32'(err), 32'd1);
        chk("tmo busy", 32'(busy), 32'd0);
        chk("tmo odata", odata, 32'h0);
        @(negedge clk);
        chk("tmo err single", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
